// File: rtl/huffman_bit_unpacker.sv
// +----------------------------------------------------------------------------+
// | huffman_bit_unpacker                                                       |
// | Huffman decode front end: buffers packed W-bit words in a 2W-bit           |
// | left-aligned bit buffer, presents a W-bit MSB-first peek window and shifts |
// | out the number of bits the downstream code-length lookup consumed.         |
// | Optional macro HUFF_UNPACK_FLUSH_EN adds an end-of-stream flush input.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module huffman_bit_unpacker #(
  parameter int W = 8,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_in,
  input  logic         en_in,
  output logic         rdy_in,
  output logic [W-1:0] d_out,
  output logic         v_out,
  input  logic [C-1:0] w_in,
`ifdef HUFF_UNPACK_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         en_cons
);

  localparam int CNT_W = C + 2;
  localparam logic [CNT_W-1:0] c_word = CNT_W'(W);

  logic [2*W-1:0]   r_buf;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_req;
  logic [CNT_W-1:0] w_we;
  logic [CNT_W-1:0] w_cnt_rem;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic [2*W-1:0]   w_shifted;
  logic [2*W-1:0]   w_word_pos;
  logic [2*W-1:0]   w_buf_nxt;

  assign rdy_in = (r_cnt <= c_word);
  assign d_out  = r_buf[2*W-1:W];

`ifdef HUFF_UNPACK_FLUSH_EN
  assign v_out = flush ? (r_cnt != '0) : (r_cnt >= c_word);
`else
  assign v_out = (r_cnt >= c_word);
`endif

  always_comb begin
    w_req = {2'b00, w_in};
    w_we  = '0;
    if (en_cons && v_out) begin
      w_we = (w_req > c_word) ? c_word : w_req;
    end
`ifdef HUFF_UNPACK_FLUSH_EN
    // Draining past the valid bits just empties the buffer; the bits below
    // cnt are already zero, so clamping to cnt gives the same shifted image.
    if (w_we > r_cnt) begin
      w_we = r_cnt;
    end
`endif
    w_load     = en_in && rdy_in;
    w_shifted  = r_buf << w_we;
    w_cnt_rem  = r_cnt - w_we;
    w_word_pos = {d_in, {W{1'b0}}} >> w_cnt_rem;
    w_buf_nxt  = w_load ? (w_shifted | w_word_pos) : w_shifted;
    w_cnt_nxt  = w_load ? (w_cnt_rem + c_word) : w_cnt_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire
